// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator arithmetic core.
// Status-bit positions match the register slave's status read-back word.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_SUB     = 3'd1,
        OP_MUL     = 3'd2,
        OP_DIV     = 3'd3,
        OP_AND     = 3'd4,
        OP_OR      = 3'd5,
        OP_XOR     = 3'd6,
        OP_ILLEGAL = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ALU  = 2'd1,
        ST_MUL  = 2'd2,
        ST_DIV  = 2'd3
    } state_e;

    localparam int STAT_DONE    = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_DIV0    = 2;
    localparam int STAT_ILLEGAL = 3;
    localparam int STAT_OVF     = 4;

endpackage

// File: rtl/calc_divider.sv
// Iterative restoring divider: one quotient bit per cycle, done_o is high
// for one cycle after DATA_WIDTH iterations. Used only when CALC_DIV_EN is defined.
module calc_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] quot_o,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic                  done_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [W:0]    shift_s, trial_s;

    // Next-state: load on start, then shift in one dividend bit per cycle.
    always_comb begin
        run_d   = run_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        shift_s = {rem_q, quot_q[W-1]};
        trial_s = shift_s - {1'b0, dvs_q};
        if (start_i) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            quot_d = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
        end else if (run_q) begin
            if (cnt_q == CW'(DATA_WIDTH)) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                // A clear borrow bit means the trial subtraction fits.
                if (!trial_s[W]) begin
                    rem_d  = trial_s[W-1:0];
                    quot_d = {quot_q[W-2:0], 1'b1};
                end else begin
                    rem_d  = shift_s[W-1:0];
                    quot_d = {quot_q[W-2:0], 1'b0};
                end
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;
    assign done_o = run_q && (cnt_q == CW'(DATA_WIDTH));

endmodule

// File: rtl/calc_core.sv
// Calculator arithmetic engine: single-cycle ALU, shift-add multiplier and
// optional restoring divider (enabled by defining CALC_DIV_EN).
module calc_core
    import calc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  start,
    input  logic                  clear,
    input  logic [2:0]            opcode,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic [DATA_WIDTH-1:0] result_lo,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic                  busy,
    output logic                  done,
    output logic                  err_div0,
    output logic                  err_illegal,
    output logic                  ovf
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    state_e        state_q, state_d;
    opcode_e       opc_q, opc_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, mhi_q, mhi_d, mlo_q, mlo_d;
    logic [W-1:0]  rlo_q, rlo_d, rhi_q, rhi_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d, done_q, done_d, div0_q, div0_d;
    logic          ill_q, ill_d, ovf_q, ovf_d;
    logic [W:0]    sum_s, diff_s, mstep_s;

`ifdef CALC_DIV_EN
    logic         div_start_s, div_done_s;
    logic [W-1:0] div_quot_s, div_rem_s;

    calc_divider #(.DATA_WIDTH(DATA_WIDTH)) u_div (
        .clk        (S_AXI_ACLK),
        .rst_n      (S_AXI_ARESETN),
        .start_i    (div_start_s),
        .dividend_i (operand_a),
        .divisor_i  (operand_b),
        .quot_o     (div_quot_s),
        .rem_o      (div_rem_s),
        .done_o     (div_done_s)
    );
`endif

    // FSM next-state, datapath and sticky-flag update.
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        a_d     = a_q;
        b_d     = b_q;
        mhi_d   = mhi_q;
        mlo_d   = mlo_q;
        cnt_d   = cnt_q;
        rlo_d   = rlo_q;
        rhi_d   = rhi_q;
        done_d  = clear ? 1'b0 : done_q;
        div0_d  = clear ? 1'b0 : div0_q;
        ill_d   = clear ? 1'b0 : ill_q;
        ovf_d   = clear ? 1'b0 : ovf_q;
        sum_s   = {1'b0, a_q} + {1'b0, b_q};
        diff_s  = {1'b0, a_q} - {1'b0, b_q};
        mstep_s = {1'b0, mhi_q} + (mlo_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
`ifdef CALC_DIV_EN
        div_start_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opc_d  = opcode_e'(opcode);
                    a_d    = operand_a;
                    b_d    = operand_b;
                    mhi_d  = '0;
                    mlo_d  = operand_b;
                    cnt_d  = '0;
                    done_d = 1'b0;
                    div0_d = 1'b0;
                    ill_d  = 1'b0;
                    ovf_d  = 1'b0;
                    case (opcode_e'(opcode))
                        OP_MUL: state_d = ST_MUL;
`ifdef CALC_DIV_EN
                        OP_DIV: begin
                            if (operand_b != '0) begin
                                state_d     = ST_DIV;
                                div_start_s = 1'b1;
                            end else begin
                                state_d = ST_ALU;
                            end
                        end
`endif
                        default: state_d = ST_ALU;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALU: begin
                rlo_d   = '0;
                rhi_d   = '0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
                case (opc_q)
                    OP_ADD: begin
                        rlo_d = sum_s[W-1:0];
                        ovf_d = sum_s[W];
                    end
                    OP_SUB: begin
                        rlo_d = diff_s[W-1:0];
                        ovf_d = diff_s[W];
                    end
                    OP_AND: rlo_d = a_q & b_q;
                    OP_OR:  rlo_d = a_q | b_q;
                    OP_XOR: rlo_d = a_q ^ b_q;
`ifdef CALC_DIV_EN
                    // Only a zero divisor reaches the ALU state with OP_DIV.
                    OP_DIV: begin
                        rlo_d  = '1;
                        rhi_d  = a_q;
                        div0_d = 1'b1;
                    end
`endif
                    default: ill_d = 1'b1;
                endcase
            end
            ST_MUL: begin
                if (cnt_q == CW'(DATA_WIDTH)) begin
                    rlo_d   = mlo_q;
                    rhi_d   = mhi_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    mhi_d = mstep_s[W:1];
                    mlo_d = {mstep_s[0], mlo_q[W-1:1]};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DIV: begin
`ifdef CALC_DIV_EN
                if (div_done_s) begin
                    rlo_d   = div_quot_s;
                    rhi_d   = div_rem_s;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DIV;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= ST_IDLE;
            opc_q   <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            mhi_q   <= '0;
            mlo_q   <= '0;
            cnt_q   <= '0;
            rlo_q   <= '0;
            rhi_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mhi_q   <= mhi_d;
            mlo_q   <= mlo_d;
            cnt_q   <= cnt_d;
            rlo_q   <= rlo_d;
            rhi_q   <= rhi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
            ill_q   <= ill_d;
            ovf_q   <= ovf_d;
        end
    end

    assign result_lo   = rlo_q;
    assign result_hi   = rhi_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_div0    = div0_q;
    assign err_illegal = ill_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core: directed and random operations against
// an arithmetic reference model; honours CALC_DIV_EN.
module tb_calc_core;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         clear = 1'b0;
    logic [2:0]   opcode = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result_lo, result_hi;
    logic         busy, done, err_div0, err_illegal, ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    calc_core #(.DATA_WIDTH(W)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .start         (start),
        .clear         (clear),
        .opcode        (opcode),
        .operand_a     (a),
        .operand_b     (b),
        .result_lo     (result_lo),
        .result_hi     (result_hi),
        .busy          (busy),
        .done          (done),
        .err_div0      (err_div0),
        .err_illegal   (err_illegal),
        .ovf           (ovf)
    );

    // {hi, lo, busy, done, div0, illegal, ovf}
    function automatic logic [68:0] snap();
        return {result_hi, result_lo, busy, done, err_div0, err_illegal, ovf};
    endfunction

    task automatic model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [68:0] exp, output int lat);
        longint unsigned p;
        logic [W-1:0] lo, hi;
        logic ov, d0, il;
        lo = '0; hi = '0; ov = 1'b0; d0 = 1'b0; il = 1'b0; lat = 1;
        case (op)
            3'd0: begin
                p = x; p = p + y;
                lo = p[31:0];
                ov = (p > 64'h0000_0000_FFFF_FFFF);
            end
            3'd1: begin lo = x - y; ov = (x < y); end
            3'd2: begin
                p = x; p = p * y;
                lo = p[31:0]; hi = p[63:32]; lat = W + 1;
            end
            3'd3: begin
`ifdef CALC_DIV_EN
                if (y == '0) begin
                    lo = '1; hi = x; d0 = 1'b1;
                end else begin
                    lo = x / y; hi = x % y; lat = W + 1;
                end
`else
                il = 1'b1;
`endif
            end
            3'd4: lo = x & y;
            3'd5: lo = x | y;
            3'd6: lo = x ^ y;
            default: il = 1'b1;
        endcase
        exp = {hi, lo, 1'b0, 1'b1, d0, il, ov};
    endtask

    // Issue one operation, scramble inputs afterwards, wait (bounded) for done.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int cyc, output logic busy0);
        @(negedge clk);
        opcode = op; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        opcode = 3'($urandom); a = $urandom; b = $urandom;
        busy0 = busy & ~done;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (snap() !== 69'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", snap(), 69'd0);
        end
        rst_n = 1'b1;
    endtask

    task automatic run_checked(input string name, input logic [2:0] op,
                               input logic [W-1:0] x, input logic [W-1:0] y);
        logic [68:0] exp;
        int lat, cyc;
        logic busy0;
        model(op, x, y, exp, lat);
        do_op(op, x, y, cyc, busy0);
        n_vec++;
        if (busy0 !== 1'b1) begin
            n_err++;
            $display("FAIL %s_busy: got %b expected 1 (op %0d)", name, busy0, op);
        end
        n_vec++;
        if (cyc !== lat) begin
            n_err++;
            $display("FAIL %s_latency: got %0d expected %0d (op %0d)", name, cyc, lat, op);
        end
        n_vec++;
        if (snap() !== exp) begin
            n_err++;
            $display("FAIL %s_result: op %0d a %h b %h got %h expected %h", name, op, x, y, snap(), exp);
        end
    endtask

    task automatic test_directed();
        run_checked("add_carry", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        run_checked("sub_borrow", 3'd1, 32'd3, 32'd5);
        run_checked("mul_big", 3'd2, 32'h0001_0000, 32'h0001_0000);
        run_checked("div_100_7", 3'd3, 32'd100, 32'd7);
        run_checked("div_by_0", 3'd3, 32'd5, 32'd0);
        run_checked("illegal", 3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
        run_checked("xor", 3'd6, 32'hF0F0_1234, 32'h0FF0_FFFF);
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic [2:0] op;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = $urandom;
            case ($urandom_range(0, 3))
                0: y = '0;
                1: y = $urandom_range(1, 15);
                default: y = $urandom;
            endcase
            run_checked("random", op, x, y);
        end
    endtask

    task automatic test_start_while_busy();
        logic [68:0] exp;
        int cyc;
        @(negedge clk);
        opcode = 3'd2; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        opcode = 3'd0; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 10;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc !== W + 1) begin
            n_err++;
            $display("FAIL busy_start_latency: got %0d expected %0d", cyc, W + 1);
        end
        exp = {32'd0, 32'd12, 1'b0, 1'b1, 3'b000};
        n_vec++;
        if (snap() !== exp) begin
            n_err++;
            $display("FAIL busy_start_result: got %h expected %h", snap(), exp);
        end
        run_checked("add_after_mul", 3'd0, 32'd1, 32'd1);
    endtask

    task automatic test_clear();
        logic [68:0] exp;
        int cyc;
        run_checked("clr_illegal", 3'd7, 32'd9, 32'd9);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        n_vec++;
        if (snap() !== 69'd0) begin
            n_err++;
            $display("FAIL clear_illegal: got %h expected %h", snap(), 69'd0);
        end
        run_checked("clr_add", 3'd0, 32'hFFFF_FFFF, 32'd2);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        exp = {32'd0, 32'd1, 5'b00000};
        n_vec++;
        if (snap() !== exp) begin
            n_err++;
            $display("FAIL clear_keeps_result: got %h expected %h", snap(), exp);
        end
        // clear in the middle of a multiply must not disturb it
        @(negedge clk); opcode = 3'd2; a = 32'd7; b = 32'd9; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        cyc = 5;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        exp = {32'd0, 32'd63, 1'b0, 1'b1, 3'b000};
        n_vec++;
        if (snap() !== exp || cyc !== W + 1) begin
            n_err++;
            $display("FAIL clear_while_busy: got %h cyc %0d expected %h cyc %0d", snap(), cyc, exp, W + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [68:0] exp;
        @(negedge clk); opcode = 3'd0; a = 32'd2; b = 32'd3; start = 1'b1;
        @(negedge clk); opcode = 3'd1; a = 32'd9; b = 32'd4;
        @(negedge clk); start = 1'b0;
        exp = {32'd0, 32'd5, 1'b0, 1'b1, 3'b000};
        n_vec++;
        if (snap() !== exp) begin
            n_err++;
            $display("FAIL b2b_first: got %h expected %h", snap(), exp);
        end
        @(negedge clk);
        n_vec++;
        if (snap() !== exp) begin
            n_err++;
            $display("FAIL b2b_ignored: got %h expected %h", snap(), exp);
        end
        run_checked("b2b_next", 3'd5, 32'hA000_0001, 32'h0500_0010);
    endtask

    task automatic test_abort();
        logic saw_done;
        @(negedge clk);
`ifdef CALC_DIV_EN
        opcode = 3'd3;
`else
        opcode = 3'd2;
`endif
        a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (snap() !== 69'd0) begin
            n_err++;
            $display("FAIL abort_outputs: got %h expected %h", snap(), 69'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_done = saw_done | done | busy;
        end
        n_vec++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: got %b expected 0", saw_done);
        end
        run_checked("after_abort", 3'd0, 32'd7, 32'd8);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_clear();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/calc_core.md
# calc_core

Arithmetic engine that sits directly downstream of the AXI4-Lite register slave in the calculator IP. It consumes the operand, opcode and start pulse decoded from the slave's software-visible registers. It executes one operation at a time, single-cycle or iterative, and returns a 2×DATA_WIDTH result plus sticky status flags for the slave's read-back registers.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and result-half width; must be ≥ 2

Ports:
- S_AXI_ACLK  in  1  clock; one clock domain, shared with the register slave
- S_AXI_ARESETN  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, derived from a software write of control bit0
- clear  in  1  one-cycle pulse; clears done/err_div0/err_illegal/ovf
- opcode  in  3  operation select; sampled with start
- operand_a  in  DATA_WIDTH  sampled with start
- operand_b  in  DATA_WIDTH  sampled with start
- result_lo  out  DATA_WIDTH  sum/difference/logic result, low product, or quotient
- result_hi  out  DATA_WIDTH  high product or remainder; 0 for other opcodes
- busy  out  1  operation in progress
- done  out  1  sticky; set when a result is written
- err_div0  out  1  sticky; divide by zero
- err_illegal  out  1  sticky; unsupported opcode
- ovf  out  1  sticky; ADD carry-out or SUB borrow

## Operation
- Opcodes are unsigned: 0 ADD, 1 SUB, 2 MUL (full 2×DATA_WIDTH product), 3 DIV (quotient in lo, remainder in hi), 4 AND, 5 OR, 6 XOR, 7 illegal.
- FSM states: IDLE, ALU, MUL, DIV.
- IDLE + start: latch opcode and operands, clear all sticky flags, drive busy=1. Next state is ALU for opcodes 0, 1, 4–7 and for DIV with operand_b=0. It is MUL for 2 and DIV for 3 with operand_b≠0.
- ALU: write results and flags, set done, return to IDLE.
- MUL: radix-2 shift-add, one iteration per cycle, DATA_WIDTH iterations. After the last iteration, write the result, set done and return to IDLE.
- DIV: restoring division, one quotient bit per cycle, DATA_WIDTH iterations. Then write the result, set done and return to IDLE.
- DIV by zero: result_lo = all ones, result_hi = operand_a, err_div0=1, done=1.
- Illegal opcode: results = 0, err_illegal=1, done=1.
- ADD/SUB: ovf = carry-out or borrow; result_lo wraps modulo 2^DATA_WIDTH.
- start while busy: ignored, with no effect on state, latched operands or flags.
- start and clear in the same cycle in IDLE: start wins, since start clears the flags anyway.
- clear while busy: clears the sticky flags only; the operation continues.
- Operand or opcode changes after start have no effect until the next accepted start.
- result_lo/result_hi hold their value until the next result is written. They are not cleared by start or clear.

## Timing
- Reset: all outputs 0, FSM IDLE, iteration counter 0. Reset asserted mid-operation aborts immediately; no done is produced.
- start accepted at rising edge t. busy=1 from t until the edge at which done rises, where busy falls.
- ALU-class ops and DIV by zero: results and done valid after edge t+1. Latency is 1 cycle.
- MUL and DIV: done after edge t+DATA_WIDTH+1, which is 33 cycles for the default width.
- Back-to-back: a start at the same edge busy falls is ignored. The earliest accepted start is the cycle after done rises.
- Flags change only at a result-write edge, or at start/clear edges.

## Configuration
- CALC_DIV_EN defined: the divider is instantiated and opcode 3 executes as above.
- CALC_DIV_EN undefined: no divider logic; opcode 3 behaves as illegal (1-cycle latency, err_illegal=1, results 0). DIV-by-zero handling is absent.

## Structure
- Package calc_pkg:
  - opcode enum (OP_ADD…OP_XOR, OP_ILLEGAL)
  - FSM state enum
  - status-bit position constants (DONE, BUSY, DIV0, ILLEGAL, OVF), shared with the register slave's status read-back
- Sub-module calc_divider: iterative restoring divider with a start/done handshake and its own counter. It is instantiated only under CALC_DIV_EN.
- The multiplier, ALU and FSM live in calc_core.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 → 1 cycle later: result_lo=0x00000000, result_hi=0, ovf=1, done=1.
- MUL 0x00010000 × 0x00010000 → busy for 32 cycles; at cycle 33: result_hi=0x00000001, result_lo=0x00000000, done=1.
- DIV 100 / 7 (CALC_DIV_EN) → cycle 33: result_lo=14, result_hi=2. DIV 5 / 0 → cycle 1: result_lo=0xFFFFFFFF, result_hi=5, err_div0=1.
- MUL 3×4 started, then start ADD 1+1 at cycle 10 → ADD ignored; cycle 33 result_lo=12; an ADD issued after done yields 2.
- Opcode 7, then clear → err_illegal=1 and done=1 after 1 cycle; both return to 0 the cycle after clear, results unchanged.
- Assert S_AXI_ARESETN low at cycle 15 of a DIV → all outputs 0 immediately, no done after release; a new ADD completes normally.
